// File: rtl/hs_tx_pkg.sv
// Shared types and defaults for the req/ack source-side arbiter (hs_tx_arbiter).
package hs_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int DEF_GAP_CYCLES = 3;
  localparam int DEF_TIMEOUT    = 64;

  // Index width for a requester pool; never below one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hs_tx_arbiter_rr.sv
// Combinational round-robin picker: first set valid bit at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PW-1:0]      idx_o,
  output logic               any_o
);

  int j;

  // Scan offsets from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (valid_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = PW'(j);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hs_tx_arbiter.sv
// Source side of the req/ack crossing: round-robin accept, hold word on data, wait for ack, low gap.
// Define HS_TX_ARB_STATS_EN to add the xfer_cnt / tmo_cnt_total statistics outputs.
module hs_tx_arbiter
  import hs_tx_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int N          = 4,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                       clka,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         src_valid,
  input  logic [NUM_REQ*N-1:0]       src_data,
  output logic [NUM_REQ-1:0]         src_ready,
  output logic                       data_req,
  output logic [N-1:0]               data,
  input  logic                       data_ack,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_timeout
`ifdef HS_TX_ARB_STATS_EN
  ,
  output logic [15:0]                xfer_cnt,
  output logic [7:0]                 tmo_cnt_total
`endif
);

  localparam int PW = ptr_width(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e          state_q, state_d;
  logic            data_req_q, data_req_d;
  logic [N-1:0]    data_q, data_d;
  logic [PW-1:0]   grant_id_q, grant_id_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            ack_s1_q, ack_s2_q;
  logic            ack_rise, ack_ok, ack_tmo;

  logic [NUM_REQ-1:0] gnt_onehot;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [N-1:0]       src_word [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign src_word[gi] = src_data[gi*N +: N];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr (
    .valid_i (src_valid),
    .ptr_i   (ptr_q),
    .grant_o (gnt_onehot),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  // An ack landing on the timeout cycle wins: it is a success, not an error.
  assign ack_rise = ack_s1_q & ~ack_s2_q;
  assign ack_ok   = (state_q == REQ) && ack_rise;
  assign ack_tmo  = (state_q == REQ) && !ack_rise && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    data_req_d = data_req_q;
    data_d     = data_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    err_d      = 1'b0;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          data_d     = src_word[gnt_idx];
          grant_id_d = gnt_idx;
          ptr_d      = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
          data_req_d = 1'b1;
          tmo_d      = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (ack_ok || ack_tmo) begin
          data_req_d = 1'b0;
          gap_d      = '0;
          err_d      = ack_tmo;
          state_d    = GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q    <= IDLE;
      data_req_q <= 1'b0;
      data_q     <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      gap_q      <= '0;
      ack_s1_q   <= 1'b0;
      ack_s2_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_req_q <= data_req_d;
      data_q     <= data_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      ack_s1_q   <= data_ack;
      ack_s2_q   <= ack_s1_q;
    end
  end

  assign src_ready   = (state_q == IDLE && gnt_any) ? gnt_onehot : '0;
  assign data_req    = data_req_q;
  assign data        = data_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;

`ifdef HS_TX_ARB_STATS_EN
  logic [15:0] xfer_cnt_q;
  logic [7:0]  tmo_total_q;

  always_ff @(posedge clka) begin
    if (rst) begin
      xfer_cnt_q  <= '0;
      tmo_total_q <= '0;
    end else begin
      if (ack_ok) xfer_cnt_q <= xfer_cnt_q + 16'd1;
      if (ack_tmo && tmo_total_q != 8'hFF) tmo_total_q <= tmo_total_q + 8'd1;
    end
  end

  assign xfer_cnt      = xfer_cnt_q;
  assign tmo_cnt_total = tmo_total_q;
`endif

endmodule

// File: tb/tb_hs_tx_arbiter.sv
// Self-checking bench for hs_tx_arbiter; stats outputs checked when HS_TX_ARB_STATS_EN is defined.
module tb_hs_tx_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int N          = 4;
  localparam int GAP_CYCLES = 3;
  localparam int TIMEOUT    = 64;
  localparam int NO_ACK     = 1000;

  logic                       clka = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         src_valid;
  logic [NUM_REQ*N-1:0]       src_data;
  logic [NUM_REQ-1:0]         src_ready;
  logic                       data_req;
  logic [N-1:0]               data;
  logic                       data_ack;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic                       busy;
  logic                       err_timeout;
`ifdef HS_TX_ARB_STATS_EN
  logic [15:0]                xfer_cnt;
  logic [7:0]                 tmo_cnt_total;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: rotation pointer, last accepted word/index, outcome tallies.
  int           ptr_m = 0;
  int           exp_gid_m = 0;
  logic [N-1:0] exp_data_m = '0;
  int           xfer_m = 0;
  int           tmo_m = 0;

  hs_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .N          (N),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clka          (clka),
    .rst           (rst),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_ready     (src_ready),
    .data_req      (data_req),
    .data          (data),
    .data_ack      (data_ack),
    .grant_id      (grant_id),
    .busy          (busy),
    .err_timeout   (err_timeout)
`ifdef HS_TX_ARB_STATS_EN
    ,
    .xfer_cnt      (xfer_cnt),
    .tmo_cnt_total (tmo_cnt_total)
`endif
  );

  always #5 clka = ~clka;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clka);
    @(negedge clka);
    #1;
  endtask

  function automatic int model_grant(input logic [NUM_REQ-1:0] v);
    int i;
    for (int k = 0; k < NUM_REQ; k++) begin
      i = (ptr_m + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr_m = 0; exp_gid_m = 0; exp_data_m = '0; xfer_m = 0; tmo_m = 0;
  endtask

  // One full transfer starting in IDLE; d = clka cycles after data_req rises before the ack pulse.
  task automatic do_xfer(input logic [NUM_REQ-1:0] vld, input int d, input bit spur, output int gid_obs);
    int g, exp_high, high, busy_n;
    bit exp_tmo;
    logic [NUM_REQ-1:0] exp_rdy;
    for (int i = 0; i < NUM_REQ; i++) src_data[i*N +: N] = N'($urandom);
    src_valid = vld;
    g = model_grant(vld);
    exp_rdy = '0;
    exp_rdy[g] = 1'b1;
    #1;
    n_cmp++;
    if (src_ready !== exp_rdy) begin
      n_bad++; $display("FAIL src_ready: got %b want %b (valid %b)", src_ready, exp_rdy, vld);
    end
    step();
    src_valid = '0;
    #1;
    exp_data_m = src_data[g*N +: N];
    exp_gid_m = g;
    ptr_m = (g + 1) % NUM_REQ;
    gid_obs = int'(grant_id);
    n_cmp++;
    if (data_req !== 1'b1 || busy !== 1'b1 || src_ready !== '0) begin
      n_bad++; $display("FAIL accept_ctl: req=%b busy=%b rdy=%b want 1 1 0", data_req, busy, src_ready);
    end
    n_cmp++;
    if (data !== exp_data_m || int'(grant_id) !== g) begin
      n_bad++; $display("FAIL accept_word: data=%h gid=%0d want %h %0d", data, grant_id, exp_data_m, g);
    end
    exp_tmo  = (d + 2 > TIMEOUT);
    exp_high = exp_tmo ? TIMEOUT : d + 2;
    high = 1;
    while (data_req === 1'b1 && high <= TIMEOUT + 4) begin
      data_ack = (high == d + 1);
      step();
      if (data_req === 1'b1) high++;
      if (data_req === 1'b1 && data !== exp_data_m) begin
        n_cmp++; n_bad++; $display("FAIL hold_data: data=%h want %h", data, exp_data_m);
      end
    end
    data_ack = 1'b0;
    n_cmp++;
    if (high !== exp_high) begin
      n_bad++; $display("FAIL req_len: high %0d cycles want %0d (ack delay %0d)", high, exp_high, d);
    end
    n_cmp++;
    if (err_timeout !== exp_tmo || busy !== 1'b1 || data !== exp_data_m) begin
      n_bad++; $display("FAIL gap_entry: err=%b busy=%b data=%h want %b 1 %h", err_timeout, busy, data, exp_tmo, exp_data_m);
    end
    if (exp_tmo) tmo_m++; else xfer_m++;
    if (spur) data_ack = 1'b1;
    busy_n = 1;
    step();
    data_ack = 1'b0;
    n_cmp++;
    if (err_timeout !== 1'b0) begin
      n_bad++; $display("FAIL err_pulse_len: err=%b want 0", err_timeout);
    end
    if (busy === 1'b1) busy_n++;
    while (busy === 1'b1 && busy_n <= GAP_CYCLES + 4) begin
      step();
      if (busy === 1'b1) busy_n++;
    end
    n_cmp++;
    if (busy_n !== GAP_CYCLES || data_req !== 1'b0) begin
      n_bad++; $display("FAIL gap_len: busy %0d cycles req=%b want %0d 0", busy_n, data_req, GAP_CYCLES);
    end
    n_cmp++;
    if (data !== exp_data_m || int'(grant_id) !== exp_gid_m) begin
      n_bad++; $display("FAIL after_gap: data=%h gid=%0d want %h %0d", data, grant_id, exp_data_m, exp_gid_m);
    end
    $display("xfer valid=%b grant=%0d data=%h ack_delay=%0d timeout=%0b", vld, g, exp_data_m, d, exp_tmo);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    src_valid = '0;
    data_ack = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    src_data = '0;
    apply_reset();
    n_cmp++;
    if (data_req !== 1'b0 || data !== '0 || grant_id !== '0) begin
      n_bad++; $display("FAIL reset_regs: req=%b data=%h gid=%0d want 0 0 0", data_req, data, grant_id);
    end
    n_cmp++;
    if (busy !== 1'b0 || err_timeout !== 1'b0 || src_ready !== '0) begin
      n_bad++; $display("FAIL reset_ctl: busy=%b err=%b rdy=%b want 0 0 0", busy, err_timeout, src_ready);
    end
    $display("reset checked");
  endtask

  task automatic test_fair();
    int gid, prev;
    apply_reset();
    prev = -1;
    for (int k = 0; k < 2 * NUM_REQ; k++) begin
      do_xfer('1, $urandom_range(0, 4), 1'b0, gid);
      n_cmp++;
      if (gid !== k % NUM_REQ || gid == prev) begin
        n_bad++; $display("FAIL rotation: step %0d grant %0d want %0d (prev %0d)", k, gid, k % NUM_REQ, prev);
      end
      prev = gid;
    end
  endtask

  task automatic test_single();
    int gid;
    do_xfer(4'b0100, 3, 1'b0, gid);
    n_cmp++;
    if (gid !== 2) begin
      n_bad++; $display("FAIL single_grant: grant %0d want 2", gid);
    end
  endtask

  task automatic test_timeout();
    int gid;
    do_xfer('1, NO_ACK, 1'b0, gid);
    do_xfer('1, 1, 1'b0, gid);
    do_xfer('1, TIMEOUT - 2, 1'b0, gid);
    do_xfer('1, TIMEOUT - 1, 1'b0, gid);
  endtask

  task automatic test_spurious();
    int gid;
    do_xfer(4'b0010, 2, 1'b1, gid);
    data_ack = 1'b1;
    step();
    data_ack = 1'b0;
    step(); step(); step();
    n_cmp++;
    if (busy !== 1'b0 || data_req !== 1'b0) begin
      n_bad++; $display("FAIL idle_ack_ctl: busy=%b req=%b want 0 0", busy, data_req);
    end
    n_cmp++;
    if (data !== exp_data_m || int'(grant_id) !== exp_gid_m) begin
      n_bad++; $display("FAIL idle_ack_word: data=%h gid=%0d want %h %0d", data, grant_id, exp_data_m, exp_gid_m);
    end
    $display("spurious ack in idle checked");
    do_xfer(4'b1001, 0, 1'b0, gid);
  endtask

  task automatic test_random();
    int gid, d;
    for (int t = 0; t < 16; t++) begin
      d = ($urandom_range(0, 7) == 0) ? NO_ACK : $urandom_range(0, 12);
      do_xfer(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), d, 1'($urandom_range(0, 1)), gid);
    end
  endtask

  task automatic test_reset_mid();
    int gid;
    src_valid = 4'b0100;
    step();
    src_valid = '0;
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    n_cmp++;
    if (data_req !== 1'b0 || busy !== 1'b0 || grant_id !== '0 || data !== '0) begin
      n_bad++; $display("FAIL mid_reset: req=%b busy=%b gid=%0d data=%h want 0 0 0 0", data_req, busy, grant_id, data);
    end
    rst = 1'b0;
    model_reset();
    do_xfer(4'b1010, 2, 1'b0, gid);
    n_cmp++;
    if (gid !== 1) begin
      n_bad++; $display("FAIL post_reset_grant: grant %0d want 1", gid);
    end
  endtask

`ifdef HS_TX_ARB_STATS_EN
  task automatic test_stats();
    int gid;
    apply_reset();
    for (int k = 0; k < 3; k++) do_xfer('1, $urandom_range(0, 5), 1'b0, gid);
    do_xfer('1, NO_ACK, 1'b0, gid);
    n_cmp++;
    if (xfer_cnt !== 16'(xfer_m) || tmo_cnt_total !== 8'(tmo_m)) begin
      n_bad++; $display("FAIL stats: xfer=%0d tmo=%0d want %0d %0d", xfer_cnt, tmo_cnt_total, xfer_m, tmo_m);
    end
    $display("stats xfer=%0d tmo=%0d", xfer_cnt, tmo_cnt_total);
  endtask
`endif

  initial begin
    rst = 1'b1;
    src_valid = '0;
    src_data = '0;
    data_ack = 1'b0;
    test_reset();
    test_fair();
    test_single();
    test_timeout();
    test_spurious();
    test_random();
    test_reset_mid();
`ifdef HS_TX_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hs_tx_arbiter.md
Name: hs_tx_arbiter

Overview:
- Source-side controller for the req/ack clock-crossing channel. It shares one channel between NUM_REQ local requesters using round-robin arbitration.
- Captures the winner's word, holds it on data, and raises data_req. It waits for the receiver's single-cycle ack pulse, synchronised into clka, then drops data_req and enforces a low gap so the receiver sees a clean falling edge.
- Sits in the clka domain, directly facing the clkb-domain receiver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- N, 4, data word width.
- GAP_CYCLES, 3, clka cycles data_req stays low after a transfer (≥1).
- TIMEOUT, 64, clka cycles to wait for ack before abandoning (≥4).

Ports:
- clka  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- src_valid  in  NUM_REQ  per-requester request; held until accepted.
- src_data  in  NUM_REQ*N  packed words; requester i at [i*N +: N].
- src_ready  out  NUM_REQ  one-hot accept, combinational.
- data_req  out  1  registered request to receiver.
- data  out  N  registered word to receiver.
- data_ack  in  1  async ack pulse from clkb domain.
- grant_id  out  $clog2(NUM_REQ)  index of last accepted requester.
- busy  out  1  high when state != IDLE.
- err_timeout  out  1  one-cycle pulse on ack timeout.

Behaviour:
- Reset values: state=IDLE, data_req=0, data=0, grant_id=0, err_timeout=0, rr pointer=0, ack sync flops=0, counters=0.
- Ack sync: 2-flop synchroniser, ack_s1/ack_s2. ack_rise = ack_s1 & ~ack_s2 (one cycle after sync).
- States: IDLE, REQ, GAP.
- IDLE:
  - grant = first set src_valid at or after rr pointer, wrapping.
  - src_ready = onehot(grant) only in IDLE with any valid; otherwise all zero.
  - On accept edge: data <= src_data[grant], grant_id <= grant, pointer <= grant+1 mod NUM_REQ, state <= REQ, data_req <= 1.
  - data_req is high in the first cycle after accept.
- REQ:
  - data and data_req are held stable; tmo_cnt increments each cycle.
  - ack_rise → state GAP, data_req <= 0, gap_cnt <= 0.
  - tmo_cnt == TIMEOUT-1 without ack_rise → GAP, data_req <= 0, err_timeout pulses one cycle.
  - ack_rise and timeout in the same cycle → treated as success; no err_timeout.
- GAP:
  - data_req=0; data keeps its last value; ack_rise is ignored.
  - After GAP_CYCLES cycles → IDLE; tmo_cnt cleared.
- No new accept occurs outside IDLE. Minimum transfer period = 1 (accept) + ack round trip + GAP_CYCLES.
- Valid dropped by a requester before acceptance is legal; it is simply not granted.
- Rotation is fair: with all requesters valid, grant order is 0,1,..,NUM_REQ-1 and then repeats.
- Reset mid-operation: the next edge forces IDLE, data_req=0, and clears the pointer and synchroniser. The receiver sees a falling edge only.
- Constraint: the clkb ack pulse must be long enough to be sampled by clka (clkb period ≥ clka period). This is documented here, not checked in RTL.

Optional Feature:
- Macro HS_TX_ARB_STATS_EN.
- Defined: adds outputs xfer_cnt[15:0] (increments on each ack success, wraps at 0xFFFF→0) and tmo_cnt_total[7:0] (increments on each timeout, saturates at 0xFF). Both are reset to 0 by rst.
- Not defined: the ports and counters are absent. Core behaviour is identical in both cases.

Decomposition:
- Package hs_tx_pkg: state enum (IDLE, REQ, GAP); localparam function for pointer width; default GAP_CYCLES/TIMEOUT constants.
- Sub-module rr_arbiter: combinational round-robin picker with inputs valid vector and pointer, outputs one-hot grant, index, and any.
- Top holds the FSM, ack synchroniser, counters and data register.

Test Plan:
- Single requester: src_valid[2]=1, data 0xA; ack returned 3 clka after data_req rises → src_ready[2] for one cycle, data=0xA, grant_id=2, data_req low after ack_rise, next accept no earlier than GAP_CYCLES later.
- All four valid continuously, auto-ack model → grant sequence 0,1,2,3,0,1; data matches each source; no requester is granted twice in a row.
- No ack → data_req held exactly TIMEOUT cycles, err_timeout pulses once, GAP entered, next requester is then served.
- rst asserted 5 cycles into REQ → data_req=0 next edge, busy=0, pointer=0. After release with valid[1] and valid[3] set, requester 1 is granted first.
- Spurious ack pulse injected during GAP and during IDLE → ignored; state and data unchanged; no extra transfer.
- With HS_TX_ARB_STATS_EN: 3 ack'd transfers plus 1 timeout → xfer_cnt=3, tmo_cnt_total=1.
